cdb_result_arbiter: RTL and testbench

//  Round-robin arbiter for the common result bus (CDB). It picks one of 8 result sources
//  per cycle and drives the select of the downstream 8:1 32-bit result mux.
//  It registers the returned mux output as the CDB broadcast, with valid/ready backpressure.

---
 rtl/cdb_result_arbiter.sv | 75 +++++++
 tb/tb_cdb_result_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cdb_result_arbiter.sv
// cdb_result_arbiter: round-robin arbiter selecting one of 8 result sources onto the registered CDB broadcast
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid_i[8]  per-source result pending
//   req_ack_o[8]    one-hot accept for the granted source (comb)
//   mux_sel_o[3]    select for the external 8:1 result mux (comb)
//   mux_out_i       data returned by the external mux for mux_sel_o
//   cdb_valid_o, cdb_src_o, cdb_data_o  registered broadcast
//   cdb_ready_i     consumer accepts the broadcast this cycle
//   bcast_cnt_o     saturating count of completed broadcasts
module cdb_result_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req_valid_i,
  output logic [7:0]        req_ack_o,
  output logic [2:0]        mux_sel_o,
  input  logic [DATA_W-1:0] mux_out_i,
  output logic              cdb_valid_o,
  output logic [2:0]        cdb_src_o,
  output logic [DATA_W-1:0] cdb_data_o,
  input  logic              cdb_ready_i,
  output logic [CNT_W-1:0]  bcast_cnt_o
);
  logic [2:0]        ptr_q, ptr_d, win, idx;
  logic              found, slot_free, grant;
  logic              valid_q, valid_d;
  logic [2:0]        src_q, src_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // first requester at or after ptr, wrapping modulo 8
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && req_valid_i[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign slot_free = !valid_q || cdb_ready_i;
  // rst_n gating keeps req_ack low for the whole reset, not just after the first edge
  assign grant     = rst_n && slot_free && |req_valid_i;
  assign req_ack_o = grant ? 8'b1 << win : 8'h00;
  assign mux_sel_o = grant ? win : ptr_q;
  assign valid_d   = grant ? 1'b1 : slot_free ? 1'b0 : valid_q;
  assign src_d     = grant ? win : src_q;
  assign data_d    = grant ? mux_out_i : data_q;
  assign ptr_d     = grant ? win + 3'd1 : ptr_q;
  assign cnt_d     = (valid_q && cdb_ready_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  assign cdb_valid_o = valid_q;
  assign cdb_src_o   = src_q;
  assign cdb_data_o  = data_q;
  assign bcast_cnt_o = cnt_q;
endmodule

// File: tb/tb_cdb_result_arbiter.sv
// tb_cdb_result_arbiter: directed stimulus with a scoreboard-checked CDB broadcast stream
module tb_cdb_result_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  req = 8'h00;
  logic        rdy = 1'b0;
  logic [7:0]  ack;
  logic [2:0]  sel;
  logic [31:0] mux_out;
  logic        vld;
  logic [2:0]  src;
  logic [31:0] data;
  logic [3:0]  cnt;
  logic [31:0] mux_tab [8];
  logic [34:0] sb [$];
  logic [3:0]  cnt_m = 4'h0;
  int          compared = 0;
  int          mismatched = 0;
  always #5 clk = ~clk;
  assign mux_out = mux_tab[sel];
  cdb_result_arbiter #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req), .req_ack_o(ack), .mux_sel_o(sel),
    .mux_out_i(mux_out), .cdb_valid_o(vld), .cdb_src_o(src), .cdb_data_o(data),
    .cdb_ready_i(rdy), .bcast_cnt_o(cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle(input logic [7:0] r, input logic rd, input logic [7:0] ea);
    @(posedge clk);
    #1 req = r;
    rdy = rd;
    @(negedge clk);
    chk("req_ack", {24'h0, ack}, {24'h0, ea});
    for (int i = 0; i < 8; i++)
      if (ea[i]) begin
        chk("mux_sel", {29'h0, sel}, i);
        sb.push_back({3'(i), mux_tab[i]});
      end
  endtask
  always @(negedge clk) begin : monitor
    logic [34:0] e;
    if (rst_n) begin
      chk("bcast_cnt", {28'h0, cnt}, {28'h0, cnt_m});
      if (vld && rdy) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL cdb_unexpected: got src %0d data %h, expected no broadcast", src, data);
        end else begin
          e = sb.pop_front();
          chk("cdb_src", {29'h0, src}, {29'h0, e[34:32]});
          chk("cdb_data", data, e[31:0]);
        end
        if (cnt_m != 4'hF) cnt_m = cnt_m + 4'h1;
      end
    end
  end
  initial begin
    for (int i = 0; i < 8; i++) mux_tab[i] = 32'h1000_0000 + i;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, vld}, 0);
    chk("rst_src", {29'h0, src}, 0);
    chk("rst_data", data, 0);
    chk("rst_cnt", {28'h0, cnt}, 0);
    chk("rst_ack", {24'h0, ack}, 0);
    #2 rst_n = 1'b1;
    // full request walk: 0..7 then 0 again
    for (int k = 0; k < 9; k++) cycle(8'hFF, 1'b1, 8'(1 << (k % 8)));
    cycle(8'h00, 1'b1, 8'h00);
    chk("cnt_after_8", {28'h0, cnt}, 8);
    // wrap: park ptr at 6, then 6 before 0, ptr ends at 1
    cycle(8'h20, 1'b1, 8'h20);
    cycle(8'h41, 1'b1, 8'h40);
    cycle(8'h41, 1'b1, 8'h01);
    cycle(8'h03, 1'b1, 8'h02);
    // backpressure on source 2 carrying DEADBEEF
    cycle(8'h00, 1'b1, 8'h00);
    mux_tab[2] = 32'hDEAD_BEEF;
    cycle(8'h04, 1'b0, 8'h04);
    for (int k = 0; k < 3; k++) begin
      cycle(8'h10, 1'b0, 8'h00);
      chk("stall_valid", {31'h0, vld}, 1);
      chk("stall_src", {29'h0, src}, 2);
      chk("stall_data", data, 32'hDEAD_BEEF);
    end
    cycle(8'h10, 1'b1, 8'h10);
    mux_tab[2] = 32'h1000_0002;
    cycle(8'h00, 1'b1, 8'h00);
    chk("after_stall_src", {29'h0, src}, 4);
    // idle gap keeps ptr at 4
    cycle(8'h08, 1'b1, 8'h08);
    cycle(8'h00, 1'b1, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cycle(8'h00, 1'b1, 8'h00);
      chk("idle_valid", {31'h0, vld}, 0);
    end
    cycle(8'h18, 1'b1, 8'h10);
    cycle(8'h00, 1'b1, 8'h00);
    // reset in the middle of traffic
    cycle(8'hFF, 1'b1, 8'h20);
    cycle(8'hFF, 1'b1, 8'h40);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    cnt_m = 4'h0;
    #1;
    chk("mid_rst_valid", {31'h0, vld}, 0);
    chk("mid_rst_src", {29'h0, src}, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_cnt", {28'h0, cnt}, 0);
    chk("mid_rst_ack", {24'h0, ack}, 0);
    req = 8'h00;
    @(negedge clk);
    #2 rst_n = 1'b1;
    // 20 back-to-back broadcasts saturate the 4-bit counter
    for (int k = 0; k < 20; k++) cycle(8'hFF, 1'b1, 8'(1 << (k % 8)));
    cycle(8'h00, 1'b1, 8'h00);
    cycle(8'h00, 1'b1, 8'h00);
    chk("cnt_saturated", {28'h0, cnt}, 32'hF);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
